// File: rtl/param_pipe_shifter.sv
// Pipelined barrel shifter/rotator: one register stage per shift-amount bit,
// valid/ready handshake with a single global advance (no bubble collapsing).
module param_pipe_shifter #(
  parameter int unsigned N = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [(1 << N) - 1:0]  in_a,
  input  logic [N-1:0]           in_amt,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(1 << N) - 1:0]  out_y
);

  localparam int unsigned W = 1 << N;

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_ROR = 2'b01;
  localparam logic [1:0] MODE_SLL = 2'b10;
  localparam logic [1:0] MODE_SRA = 2'b11;

  // Stage registers
  logic         st_v    [N];
  logic [W-1:0] st_d    [N];
  logic [N-1:0] st_amt  [N];
  logic [1:0]   st_mode [N];

  // Stage inputs (predecessor view) and shifted data
  logic         src_v    [N];
  logic [W-1:0] src_d    [N];
  logic [N-1:0] src_amt  [N];
  logic [1:0]   src_mode [N];
  logic [W-1:0] nxt_d    [N];

  logic adv;

  // Conditional shift by k in the selected mode; k is always below W here.
  function automatic logic [W-1:0] stage_shift(input logic [W-1:0] d,
                                               input logic         en,
                                               input logic [1:0]   mode,
                                               input int unsigned  k);
    logic [W-1:0] r;
    r = d;
    if (en) begin
      unique case (mode)
        MODE_ROL: r = W'(d << k) | W'(d >> (W - k));
        MODE_ROR: r = W'(d >> k) | W'(d << (W - k));
        MODE_SLL: r = W'(d << k);
        MODE_SRA: r = W'($signed(d) >>> k);
        default:  r = d;
      endcase
    end
    return r;
  endfunction

  // Whole pipeline moves together when the output slot is free or being taken
  always_comb begin
    adv = out_ready | ~st_v[N-1];
  end

  assign in_ready  = adv;
  assign out_valid = st_v[N-1];
  assign out_y     = st_d[N-1];

  // Stage input selection and per-stage shift by 2**i when amt bit i is set
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      src_v[i]    = 1'b0;
      src_d[i]    = '0;
      src_amt[i]  = '0;
      src_mode[i] = '0;
      nxt_d[i]    = '0;
    end
    src_v[0]    = in_valid;
    src_d[0]    = in_a;
    src_amt[0]  = in_amt;
    src_mode[0] = in_mode;
    for (int unsigned i = 1; i < N; i++) begin
      src_v[i]    = st_v[i-1];
      src_d[i]    = st_d[i-1];
      src_amt[i]  = st_amt[i-1];
      src_mode[i] = st_mode[i-1];
    end
    for (int unsigned i = 0; i < N; i++) begin
      nxt_d[i] = stage_shift(src_d[i], src_amt[i][i], src_mode[i], 32'(1) << i);
    end
  end

  // Stage registers: cleared on reset, load from predecessor on advance, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        st_v[i]    <= 1'b0;
        st_d[i]    <= '0;
        st_amt[i]  <= '0;
        st_mode[i] <= '0;
      end
    end else if (adv) begin
      for (int unsigned i = 0; i < N; i++) begin
        st_v[i]    <= src_v[i];
        st_d[i]    <= nxt_d[i];
        st_amt[i]  <= src_amt[i];
        st_mode[i] <= src_mode[i];
      end
    end
  end

endmodule

// File: tb/tb_param_pipe_shifter.sv
// Scoreboard bench for param_pipe_shifter (N=3, W=8): the driver pushes expected
// results at transfer time, the monitor pops and compares on each output handshake.
module tb_param_pipe_shifter;

  localparam int unsigned N = 3;
  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [N-1:0] in_amt = '0;
  logic [1:0]   in_mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_y;

  param_pipe_shifter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_amt    (in_amt),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    int unsigned  tc;
    bit           lat;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          lat_en = 1'b1;
  bit          rand_rdy = 1'b0;
  bit          done = 1'b0;
  bit          final_done = 1'b0;
  bit          hold = 1'b0;
  bit          prev_rst = 1'b0;
  logic [W-1:0] held_y = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bit-serial reference: apply amt single-bit steps of the chosen mode
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] a,
                                             input logic [N-1:0] amt,
                                             input logic [1:0]   m);
    logic [W-1:0] r;
    r = a;
    for (int i = 0; i < int'(amt); i++) begin
      case (m)
        2'b00:   r = {r[W-2:0], r[W-1]};
        2'b01:   r = {r[0], r[W-1:1]};
        2'b10:   r = {r[W-2:0], 1'b0};
        default: r = {r[W-1], r[W-1:1]};
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: reset values, hold under backpressure, in-order scoreboard and latency
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      if (cyc != 0) begin
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_y", 32'(out_y), 32'd0);
      end
      hold = 1'b0;
    end else begin
      if (!prev_rst) check("in_ready_after_reset", 32'(in_ready), 32'd1);
      if (hold) begin
        check("hold_out_valid", 32'(out_valid), 32'd1);
        check("hold_out_y", 32'(out_y), 32'(held_y));
      end
      if (out_valid) begin
        if (!out_ready) begin
          check("stall_in_ready", 32'(in_ready), 32'd0);
          hold   = 1'b1;
          held_y = out_y;
        end else begin
          hold = 1'b0;
          if (q.size() == 0) begin
            check("unexpected_output", 32'(out_y), 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            check("out_y", 32'(out_y), 32'(e.y));
            if (e.lat) check("latency_cycle", cyc, e.tc + N);
          end
        end
      end else begin
        hold = 1'b0;
      end
      if (done && !final_done) begin
        check("pending_results", 32'(q.size()), 32'd0);
        final_done = 1'b1;
      end
    end
    prev_rst = rst_n;
  end

  // Move to just after the next rising edge; optionally randomise out_ready
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one operand and wait (bounded) for its transfer
  task automatic send(input logic [W-1:0] a, input logic [N-1:0] amt,
                      input logic [1:0] m, input logic [W-1:0] y);
    exp_t e;
    in_valid = 1'b1;
    in_a     = a;
    in_amt   = amt;
    in_mode  = m;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) begin
        e.y   = y;
        e.tc  = cyc;
        e.lat = lat_en;
        q.push_back(e);
        step();
        break;
      end
      if (t > 1000) begin
        $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        $fatal(1);
      end
      step();
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_a     = W'($urandom);
    in_amt   = N'($urandom);
    in_mode  = 2'($urandom);
    repeat (n) step();
  endtask

  logic [W-1:0] stream_exp [8];
  logic [W-1:0] r_a;
  logic [N-1:0] r_amt;
  logic [1:0]   r_m;

  initial begin
    stream_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    // Power-on reset
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // Reset mid-stream with two operands in flight
    send(8'h11, 3'd1, 2'b00, 8'h22);
    send(8'h22, 3'd2, 2'b00, 8'h88);
    rst_n = 1'b0;
    idle(3);
    q.delete();
    rst_n = 1'b1;
    idle(6);

    // Mode sweep on 0xB4
    send(8'hB4, 3'd3, 2'b00, 8'hA5);
    send(8'hB4, 3'd3, 2'b01, 8'h96);
    send(8'hB4, 3'd3, 2'b10, 8'hA0);
    send(8'hB4, 3'd3, 2'b11, 8'hF6);
    send(8'hB4, 3'd0, 2'b00, 8'hB4);
    send(8'hB4, 3'd0, 2'b01, 8'hB4);
    send(8'hB4, 3'd0, 2'b10, 8'hB4);
    send(8'hB4, 3'd0, 2'b11, 8'hB4);
    idle(N + 2);

    // Back-to-back streaming rotate of 0x01
    for (int i = 0; i < 8; i++) send(8'h01, N'(i), 2'b00, stream_exp[i]);
    idle(N + 2);

    // Backpressure: consumer stalls 4 cycles with results waiting
    lat_en = 1'b0;
    send(8'h81, 3'd1, 2'b00, 8'h03);
    send(8'h81, 3'd1, 2'b01, 8'hC0);
    send(8'h0F, 3'd4, 2'b10, 8'hF0);
    send(8'h80, 3'd1, 2'b11, 8'hC0);
    send(8'h40, 3'd2, 2'b11, 8'h10);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (4) step();
    out_ready = 1'b1;
    idle(N + 3);

    // Bubbles between sign-fill operands
    lat_en = 1'b1;
    send(8'h80, 3'd7, 2'b11, 8'hFF);
    idle(1);
    send(8'h7F, 3'd7, 2'b11, 8'h00);
    idle(1);
    send(8'h80, 3'd7, 2'b11, 8'hFF);
    idle(N + 2);

    // Random traffic against the reference model
    lat_en   = 1'b0;
    rand_rdy = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle(1);
      end else begin
        r_a   = W'($urandom);
        r_amt = N'($urandom);
        r_m   = 2'($urandom);
        send(r_a, r_amt, r_m, ref_shift(r_a, r_amt, r_m));
      end
    end
    rand_rdy  = 1'b0;
    out_ready = 1'b1;
    idle(N + 4);

    done = 1'b1;
    for (int t = 0; t < 10 && !final_done; t++) @(posedge clk);
    if (!final_done) begin
      $display("FAIL final_check: monitor did not complete, expected completion");
      $fatal(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
